// File: rtl/vga_object_ctrl.sv
// Player/obstacle position controller for a VGA game: moves objects once per frame
// at the start of vertical blanking, checks overlap, and tracks score and game-over.
module vga_object_ctrl #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int PLAYER_W    = 16,
  parameter int PLAYER_H    = 16,
  parameter int OBS_W       = 16,
  parameter int OBS_H       = 32,
  parameter int PLAYER_STEP = 4,
  parameter int OBS_STEP    = 2,
  parameter int PLAYER_X0   = 200,
  parameter int PLAYER_Y0   = 200,
  parameter int OBS_X0      = 400,
  parameter int OBS_Y0      = 100
) (
  input  logic       clock,
  input  logic       clear,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_start,
  output logic [9:0] player_x,
  output logic [9:0] player_y,
  output logic [9:0] obs_x,
  output logic [9:0] obs_y,
  output logic [1:0] state,
  output logic       collision,
  output logic [7:0] score,
  output logic       frame_update
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PLAY  = 2'b01,
    S_CHECK = 2'b10,
    S_OVER  = 2'b11
  } state_t;

  localparam logic [10:0] L_P_STEP = 11'(PLAYER_STEP);
  localparam logic [10:0] L_O_STEP = 11'(OBS_STEP);
  localparam logic [10:0] L_PY_MAX = 11'(V_ACTIVE - PLAYER_H);
  localparam logic [10:0] L_OX_WRAP = 11'(H_ACTIVE - OBS_W);
  localparam logic [10:0] L_P_W    = 11'(PLAYER_W);
  localparam logic [10:0] L_P_H    = 11'(PLAYER_H);
  localparam logic [10:0] L_O_W    = 11'(OBS_W);
  localparam logic [10:0] L_O_H    = 11'(OBS_H);
  localparam logic [9:0]  L_PX0    = 10'(PLAYER_X0);
  localparam logic [9:0]  L_PY0    = 10'(PLAYER_Y0);
  localparam logic [9:0]  L_OX0    = 10'(OBS_X0);
  localparam logic [9:0]  L_OY0    = 10'(OBS_Y0);
  localparam logic [9:0]  L_VBLANK = 10'(V_ACTIVE);

  state_t     r_state, w_state_nxt;
  logic [9:0] r_px, r_py, r_ox, r_oy;
  logic [9:0] w_px_nxt, w_py_nxt, w_ox_nxt, w_oy_nxt;
  logic [7:0] r_score, w_score_nxt;
  logic       r_match_d, r_start_d, r_start_pending;
  logic       w_match, w_strobe, w_start_rise, w_consume, w_overlap;
  logic [10:0] w_py_up, w_py_dn, w_ox_dec;

  // Edge-detect the blanking position so a stalled counter still yields one strobe
  assign w_match      = (hCount == 10'd0) && (vCount == L_VBLANK);
  assign w_strobe     = w_match && !r_match_d;
  assign w_start_rise = btn_start && !r_start_d;

  assign w_py_up  = {1'b0, r_py} - L_P_STEP;
  assign w_py_dn  = {1'b0, r_py} + L_P_STEP;
  assign w_ox_dec = {1'b0, r_ox} - L_O_STEP;

  assign w_overlap = ({1'b0, r_px} < ({1'b0, r_ox} + L_O_W)) &&
                     ({1'b0, r_ox} < ({1'b0, r_px} + L_P_W)) &&
                     ({1'b0, r_py} < ({1'b0, r_oy} + L_O_H)) &&
                     ({1'b0, r_oy} < ({1'b0, r_py} + L_P_H));

  always_comb begin
    w_state_nxt = r_state;
    w_px_nxt    = r_px;
    w_py_nxt    = r_py;
    w_ox_nxt    = r_ox;
    w_oy_nxt    = r_oy;
    w_score_nxt = r_score;
    w_consume   = 1'b0;
    case (r_state)
      S_IDLE, S_OVER: begin
        if (w_strobe && r_start_pending) begin
          w_consume   = 1'b1;
          w_state_nxt = S_PLAY;
          w_px_nxt    = L_PX0;
          w_py_nxt    = L_PY0;
          w_ox_nxt    = L_OX0;
          w_oy_nxt    = L_OY0;
          w_score_nxt = 8'd0;
        end
      end
      S_PLAY: begin
        if (w_strobe) begin
          w_state_nxt = S_CHECK;
          if (btn_up && !btn_down)
            w_py_nxt = ({1'b0, r_py} < L_P_STEP) ? 10'd0 : w_py_up[9:0];
          else if (btn_down && !btn_up)
            w_py_nxt = (w_py_dn > L_PY_MAX) ? L_PY_MAX[9:0] : w_py_dn[9:0];
          if ({1'b0, r_ox} >= L_O_STEP) begin
            w_ox_nxt = w_ox_dec[9:0];
          end else begin
            w_ox_nxt = L_OX_WRAP[9:0];
            if (r_score != 8'hFF) w_score_nxt = r_score + 8'd1;
          end
        end
      end
      S_CHECK: w_state_nxt = w_overlap ? S_OVER : S_PLAY;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state         <= S_IDLE;
      r_px            <= L_PX0;
      r_py            <= L_PY0;
      r_ox            <= L_OX0;
      r_oy            <= L_OY0;
      r_score         <= 8'd0;
      r_match_d       <= 1'b0;
      r_start_d       <= 1'b0;
      r_start_pending <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_px      <= w_px_nxt;
      r_py      <= w_py_nxt;
      r_ox      <= w_ox_nxt;
      r_oy      <= w_oy_nxt;
      r_score   <= w_score_nxt;
      r_match_d <= w_match;
      r_start_d <= btn_start;
      if (w_start_rise)   r_start_pending <= 1'b1;
      else if (w_consume) r_start_pending <= 1'b0;
    end
  end

  assign player_x     = r_px;
  assign player_y     = r_py;
  assign obs_x        = r_ox;
  assign obs_y        = r_oy;
  assign score        = r_score;
  assign state        = r_state;
  assign collision    = (r_state == S_OVER);
  assign frame_update = (r_state == S_CHECK);

endmodule
